oec_blend: RTL

OEC_BLEND -- requirements
Module: oec_blend

---
 rtl/oec_blend_pkg.sv | 12 +
 rtl/oec_blend_if.sv | 32 +++
 rtl/oec_mul_round.sv | 25 ++
 rtl/oec_blend.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/oec_blend_pkg.sv
// Shared types and constants for the OEC blend stage.
// Weights use 1.8 unsigned fixed point.
package oec_blend_pkg;
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } frame_state_t;

  localparam int W_UNITY  = 256;
  localparam int RND_HALF = 128;
  localparam int W_FRAC   = 8;
endpackage

// File: rtl/oec_blend_if.sv
// Pixel stream interface: upstream (s_*) beats in, corrected (m_*) beats out.
interface oec_blend_if #(
  parameter int DW_P = 10,
  parameter int DW_W = 9
);
  logic            s_valid;
  logic            s_ready;
  logic            s_sof;
  logic            s_eof;
  logic [DW_P-1:0] s_r;
  logic [DW_P-1:0] s_g;
  logic [DW_P-1:0] s_b;
  logic [DW_W-1:0] s_w;

  logic            m_valid;
  logic            m_ready;
  logic            m_sof;
  logic            m_eof;
  logic [DW_P-1:0] m_r;
  logic [DW_P-1:0] m_g;
  logic [DW_P-1:0] m_b;

  modport slave (
    input  s_valid, s_sof, s_eof, s_r, s_g, s_b, s_w, m_ready,
    output s_ready, m_valid, m_sof, m_eof, m_r, m_g, m_b
  );

  modport master (
    output s_valid, s_sof, s_eof, s_r, s_g, s_b, s_w, m_ready,
    input  s_ready, m_valid, m_sof, m_eof, m_r, m_g, m_b
  );
endinterface

// File: rtl/oec_mul_round.sv
// One colour component: multiply by the clamped weight, then round and clip
// the product captured in the first pipeline stage.
module oec_mul_round
  import oec_blend_pkg::*;
#(
  parameter int DW_P = 10,
  parameter int DW_W = 9
) (
  input  logic [DW_P-1:0]      pix,
  input  logic [DW_W-1:0]      w,
  output logic [DW_P+DW_W-1:0] prod,
  input  logic [DW_P+DW_W-1:0] prod_q,
  output logic [DW_P-1:0]      res
);
  localparam int              PW      = DW_P + DW_W;
  localparam logic [DW_P-1:0] PIX_MAX = '1;

  logic [PW-1:0] rounded;
  logic [PW-1:0] shifted;

  assign prod    = PW'(pix) * PW'(w);
  assign rounded = prod_q + PW'(RND_HALF);
  assign shifted = rounded >> W_FRAC;
  assign res     = (shifted > PW'(PIX_MAX)) ? PIX_MAX : shifted[DW_P-1:0];
endmodule

// File: rtl/oec_blend.sv
// Two-stage weight blend with per-frame count of attenuated pixels.
// The whole pipeline advances only when the output slot is free or drained.
module oec_blend
  import oec_blend_pkg::*;
#(
  parameter int DW_P = 10,
  parameter int DW_W = 9,
  parameter int DW_S = 20
) (
  input  logic            clk,
  input  logic            rst_n,
  oec_blend_if.slave      bus,
  output logic [DW_S-1:0] stat_cnt,
  output logic            stat_vld,
  output logic            frame_err
);
  localparam int              PW      = DW_P + DW_W;
  localparam logic [DW_W-1:0] W_ONE   = DW_W'(W_UNITY);
  localparam logic [DW_S-1:0] CNT_MAX = '1;

  logic            adv;
  logic            accept;
  logic [DW_W-1:0] w_c;
  logic            w_att;

  logic [DW_P-1:0] pix_in     [3];
  logic [PW-1:0]   prod_w     [3];
  logic [DW_P-1:0] res_w      [3];
  logic [PW-1:0]   s1_prod_reg[3];
  logic [DW_P-1:0] s2_pix_reg [3];
  logic            s1_valid_reg, s1_sof_reg, s1_eof_reg;
  logic            s2_valid_reg, s2_sof_reg, s2_eof_reg;

  assign adv         = bus.m_ready || !s2_valid_reg;
  assign bus.s_ready = adv;
  assign accept      = bus.s_valid && adv;
  assign w_c         = (bus.s_w > W_ONE) ? W_ONE : bus.s_w;
  assign w_att       = (w_c < W_ONE);

  assign pix_in[0] = bus.s_r;
  assign pix_in[1] = bus.s_g;
  assign pix_in[2] = bus.s_b;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_comp
      oec_mul_round #(.DW_P(DW_P), .DW_W(DW_W)) u_mul_round (
        .pix   (pix_in[gi]),
        .w     (w_c),
        .prod  (prod_w[gi]),
        .prod_q(s1_prod_reg[gi]),
        .res   (res_w[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_sof_reg   <= 1'b0;
      s1_eof_reg   <= 1'b0;
      s2_valid_reg <= 1'b0;
      s2_sof_reg   <= 1'b0;
      s2_eof_reg   <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        s1_prod_reg[i] <= '0;
        s2_pix_reg[i]  <= '0;
      end
    end else if (adv) begin
      s1_valid_reg <= bus.s_valid;
      s1_sof_reg   <= bus.s_sof;
      s1_eof_reg   <= bus.s_eof;
      s2_valid_reg <= s1_valid_reg;
      s2_sof_reg   <= s1_sof_reg;
      s2_eof_reg   <= s1_eof_reg;
      for (int i = 0; i < 3; i++) begin
        s1_prod_reg[i] <= prod_w[i];
        s2_pix_reg[i]  <= res_w[i];
      end
    end
  end

  assign bus.m_valid = s2_valid_reg;
  assign bus.m_sof   = s2_sof_reg;
  assign bus.m_eof   = s2_eof_reg;
  assign bus.m_r     = s2_pix_reg[0];
  assign bus.m_g     = s2_pix_reg[1];
  assign bus.m_b     = s2_pix_reg[2];

  // Frame statistics: driven by accepted input beats, not by output flow.
  frame_state_t    state_reg, state_next;
  logic [DW_S-1:0] cnt_reg, cnt_next;
  logic [DW_S-1:0] stat_cnt_reg, stat_cnt_next;
  logic            stat_vld_reg, stat_vld_next;
  logic            frame_err_reg, frame_err_next;
  logic [DW_S-1:0] cnt_first;
  logic [DW_S-1:0] cnt_inc;

  assign cnt_first = {{(DW_S-1){1'b0}}, w_att};
  assign cnt_inc   = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + cnt_first;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      stat_cnt_reg  <= '0;
      stat_vld_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      stat_cnt_reg  <= stat_cnt_next;
      stat_vld_reg  <= stat_vld_next;
      frame_err_reg <= frame_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    stat_cnt_next  = stat_cnt_reg;
    stat_vld_next  = 1'b0;
    frame_err_next = 1'b0;
    if (accept) begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.s_sof) begin
            cnt_next = cnt_first;
            if (bus.s_eof) begin
              stat_cnt_next = cnt_first;
              stat_vld_next = 1'b1;
            end else begin
              state_next = ST_ACTIVE;
            end
          end
        end
        ST_ACTIVE: begin
          if (bus.s_sof) begin
            frame_err_next = 1'b1;
            cnt_next       = cnt_first;
            if (bus.s_eof) begin
              stat_cnt_next = cnt_first;
              stat_vld_next = 1'b1;
              state_next    = ST_IDLE;
            end
          end else if (bus.s_eof) begin
            cnt_next      = cnt_inc;
            stat_cnt_next = cnt_inc;
            stat_vld_next = 1'b1;
            state_next    = ST_IDLE;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign stat_cnt  = stat_cnt_reg;
  assign stat_vld  = stat_vld_reg;
  assign frame_err = frame_err_reg;
endmodule
